mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller between EX/MEM and MEM/WB: stalls the pipe while a load/store
// waits for mem_ack. Define DMEM_TIMEOUT_EN to compile in the ACCESS watchdog and sticky err.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_dm_we,
  input  logic        ex_dm_re,
  input  logic [15:0] ex_dm_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_alu_res,
  input  logic [1:0]  ex_rf_d_sel,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_dm_q,
  output logic [1:0]  wb_rf_d_sel,
  output logic [15:0] stall_cnt,
  output logic        err
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] alu_q, alu_d;
  logic [1:0]  sel_q, sel_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_dq_q, wb_dq_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        timeout;

`ifdef DMEM_TIMEOUT_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    timeout  = 1'b0;
    // Held at zero in IDLE so every access starts counting from a clean slate.
    if (state_q == StIdle) begin
      wd_cnt_d = '0;
    end else if (!mem_ack) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
      timeout  = (wd_cnt_d == TIMEOUT_CYCLES);
    end
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    alu_d       = alu_q;
    sel_d       = sel_q;
    wb_valid_d  = 1'b0;
    wb_alu_d    = wb_alu_q;
    wb_dq_d     = wb_dq_q;
    wb_sel_d    = wb_sel_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == StAccess && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (ex_dm_we || ex_dm_re) begin
            state_d = StAccess;
            we_d    = ex_dm_we;  // we=re=1 is a store
            addr_d  = ex_dm_addr;
            wdata_d = ex_wdata;
            alu_d   = ex_alu_res;
            sel_d   = ex_rf_d_sel;
          end else begin
            wb_valid_d = 1'b1;
            wb_alu_d   = ex_alu_res;
            wb_sel_d   = ex_rf_d_sel;
            wb_dq_d    = '0;
          end
        end
      end
      StAccess: begin
        if (mem_ack || timeout) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_alu_d   = alu_q;
          wb_sel_d   = sel_q;
          wb_dq_d    = (mem_ack && !we_q) ? mem_rdata : '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      alu_q       <= '0;
      sel_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_alu_q    <= '0;
      wb_dq_q     <= '0;
      wb_sel_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      alu_q       <= alu_d;
      sel_q       <= sel_d;
      wb_valid_q  <= wb_valid_d;
      wb_alu_q    <= wb_alu_d;
      wb_dq_q     <= wb_dq_d;
      wb_sel_q    <= wb_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall       = (state_q == StAccess);
  assign mem_req     = stall;
  assign mem_we      = stall & we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_alu_res  = wb_alu_q;
  assign wb_dm_q     = wb_dq_q;
  assign wb_rf_d_sel = wb_sel_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, timeout/saturation sequences and random
// traffic against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int unsigned To = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_dm_we = 1'b0, ex_dm_re = 1'b0;
  logic [15:0] ex_dm_addr = '0;
  logic [31:0] ex_wdata = '0, ex_alu_res = '0;
  logic [1:0]  ex_rf_d_sel = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, mem_req, mem_we, wb_valid, err;
  logic [15:0] mem_addr, stall_cnt;
  logic [31:0] mem_wdata, wb_alu_res, wb_dm_q;
  logic [1:0]  wb_rf_d_sel;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(To)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_dm_we(ex_dm_we), .ex_dm_re(ex_dm_re),
    .ex_dm_addr(ex_dm_addr), .ex_wdata(ex_wdata), .ex_alu_res(ex_alu_res),
    .ex_rf_d_sel(ex_rf_d_sel), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_alu_res(wb_alu_res), .wb_dm_q(wb_dm_q),
    .wb_rf_d_sel(wb_rf_d_sel), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding transaction plus the last retirement.
  typedef struct {
    logic we;
    logic [15:0] addr;
    logic [31:0] wdata, alu;
    logic [1:0] sel;
  } txn_t;
  bit   m_busy, m_wbv, m_err;
  txn_t m_txn;
  int   m_wait, m_scnt;
  logic [31:0] m_wb_alu, m_wb_dq;
  logic [1:0]  m_wb_sel;

  task automatic retire(input logic [31:0] dq);
    m_busy = 0; m_wbv = 1; m_wb_alu = m_txn.alu; m_wb_sel = m_txn.sel; m_wb_dq = dq;
  endtask

  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_wbv = 0; m_err = 0; m_wait = 0; m_scnt = 0;
      m_txn = '{we: 0, addr: 0, wdata: 0, alu: 0, sel: 0};
      m_wb_alu = 0; m_wb_dq = 0; m_wb_sel = 0;
    end else begin
      m_wbv = 0;
      if (m_busy) begin
        m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
        if (mem_ack) retire(m_txn.we ? 32'h0 : mem_rdata);
        else begin
          m_wait++;
          if (TimeoutEn && m_wait == To) begin retire(32'h0); m_err = 1; end
        end
      end else if (ex_valid) begin
        if (ex_dm_we || ex_dm_re) begin
          m_busy = 1; m_wait = 0;
          m_txn = '{we: ex_dm_we, addr: ex_dm_addr, wdata: ex_wdata, alu: ex_alu_res,
                    sel: ex_rf_d_sel};
        end else begin
          m_wbv = 1; m_wb_alu = ex_alu_res; m_wb_sel = ex_rf_d_sel; m_wb_dq = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d stall", cyc), {31'b0, stall}, {31'b0, m_busy});
    check($sformatf("rnd%0d mem_req", cyc), {31'b0, mem_req}, {31'b0, m_busy});
    check($sformatf("rnd%0d mem_we", cyc), {31'b0, mem_we}, {31'b0, m_busy & m_txn.we});
    check($sformatf("rnd%0d wb_valid", cyc), {31'b0, wb_valid}, {31'b0, m_wbv});
    check($sformatf("rnd%0d stall_cnt", cyc), {16'b0, stall_cnt}, m_scnt);
    check($sformatf("rnd%0d err", cyc), {31'b0, err}, {31'b0, m_err});
    if (m_busy) begin
      check($sformatf("rnd%0d mem_addr", cyc), {16'b0, mem_addr}, {16'b0, m_txn.addr});
      check($sformatf("rnd%0d mem_wdata", cyc), mem_wdata, m_txn.wdata);
    end
    if (m_wbv) begin
      check($sformatf("rnd%0d wb_alu_res", cyc), wb_alu_res, m_wb_alu);
      check($sformatf("rnd%0d wb_dm_q", cyc), wb_dm_q, m_wb_dq);
      check($sformatf("rnd%0d wb_rf_d_sel", cyc), {30'b0, wb_rf_d_sel}, {30'b0, m_wb_sel});
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic we, input logic re,
                       input logic [15:0] a, input logic [31:0] wd, input logic [31:0] alu,
                       input logic [1:0] sel, input logic ack, input logic [31:0] rd);
    rst = r; ex_valid = v; ex_dm_we = we; ex_dm_re = re; ex_dm_addr = a; ex_wdata = wd;
    ex_alu_res = alu; ex_rf_d_sel = sel; mem_ack = ack; mem_rdata = rd;
  endtask

  // Inputs for one cycle and the outputs required just after its closing edge.
  typedef struct {
    logic rst, ev, we, re;
    logic [15:0] addr;
    logic [31:0] wdata, alu;
    logic [1:0] sel;
    logic ack;
    logic [31:0] rdata;
    logic full, e_stall, e_we, e_wbv;
    logic [31:0] e_alu, e_dq;
    logic [1:0] e_sel;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    logic [15:0] e_scnt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0,
                1, 0, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0, 32'h0, 16'd0};
    tbl[1]  = '{0, 1, 0, 0, 16'h0, 32'h0, 32'h1234, 2'd2, 0, 32'h0,
                0, 0, 0, 1, 32'h1234, 32'h0, 2'd2, 16'h0, 32'h0, 16'd0};
    tbl[2]  = '{0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0,
                0, 0, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0, 32'h0, 16'd0};
    tbl[3]  = '{0, 1, 0, 1, 16'h0040, 32'h77, 32'h11, 2'd1, 0, 32'h0,
                0, 1, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0040, 32'h77, 16'd0};
    tbl[4]  = '{0, 1, 0, 0, 16'h0, 32'h0, 32'hDEAD, 2'd3, 0, 32'h0,
                0, 1, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0040, 32'h77, 16'd1};
    tbl[5]  = '{0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0,
                0, 1, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0040, 32'h77, 16'd2};
    tbl[6]  = '{0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 1, 32'hCAFEF00D,
                0, 0, 0, 1, 32'h11, 32'hCAFEF00D, 2'd1, 16'h0, 32'h0, 16'd3};
    tbl[7]  = '{0, 1, 1, 1, 16'h0100, 32'hA5A5A5A5, 32'h22, 2'd0, 0, 32'h0,
                0, 1, 1, 0, 32'h0, 32'h0, 2'd0, 16'h0100, 32'hA5A5A5A5, 16'd3};
    tbl[8]  = '{0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 1, 32'hFFFFFFFF,
                0, 0, 0, 1, 32'h22, 32'h0, 2'd0, 16'h0, 32'h0, 16'd4};
    tbl[9]  = '{0, 1, 0, 1, 16'h0080, 32'h5, 32'h33, 2'd3, 0, 32'h0,
                0, 1, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0080, 32'h5, 16'd4};
    tbl[10] = '{0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0,
                0, 1, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0080, 32'h5, 16'd5};
    tbl[11] = '{1, 1, 1, 0, 16'h0123, 32'h9, 32'h9, 2'd1, 1, 32'h99,
                1, 0, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0, 32'h0, 16'd0};
    tbl[12] = '{0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 1, 32'h99,
                1, 0, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0, 32'h0, 16'd0};
    tbl[13] = '{0, 1, 0, 1, 16'h0200, 32'h0, 32'h44, 2'd1, 0, 32'h0,
                0, 1, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0200, 32'h0, 16'd0};
    tbl[14] = '{0, 1, 0, 1, 16'h0300, 32'h0, 32'h55, 2'd2, 1, 32'h1,
                0, 0, 0, 1, 32'h44, 32'h1, 2'd1, 16'h0, 32'h0, 16'd1};
    tbl[15] = '{0, 1, 0, 1, 16'h0300, 32'h0, 32'h55, 2'd2, 0, 32'h0,
                0, 1, 0, 0, 32'h0, 32'h0, 2'd0, 16'h0300, 32'h0, 16'd1};
    tbl[16] = '{0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 1, 32'h2,
                0, 0, 0, 1, 32'h55, 32'h2, 2'd2, 16'h0, 32'h0, 16'd2};

    #1;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].ev, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata,
            tbl[i].alu, tbl[i].sel, tbl[i].ack, tbl[i].rdata);
      tick();
      check($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
      check($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, tbl[i].e_stall});
      check($sformatf("vec%0d mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_we});
      check($sformatf("vec%0d wb_valid", i), {31'b0, wb_valid}, {31'b0, tbl[i].e_wbv});
      check($sformatf("vec%0d stall_cnt", i), {16'b0, stall_cnt}, {16'b0, tbl[i].e_scnt});
      check($sformatf("vec%0d err", i), {31'b0, err}, 32'h0);
      if (tbl[i].e_stall || tbl[i].full) begin
        check($sformatf("vec%0d mem_addr", i), {16'b0, mem_addr}, {16'b0, tbl[i].e_addr});
        check($sformatf("vec%0d mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      end
      if (tbl[i].e_wbv || tbl[i].full) begin
        check($sformatf("vec%0d wb_alu_res", i), wb_alu_res, tbl[i].e_alu);
        check($sformatf("vec%0d wb_dm_q", i), wb_dm_q, tbl[i].e_dq);
        check($sformatf("vec%0d wb_rf_d_sel", i), {30'b0, wb_rf_d_sel}, {30'b0, tbl[i].e_sel});
      end
    end

    // Load that is never acked.
    drive(1, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0);
    tick();
    drive(0, 1, 0, 1, 16'h0AAA, 32'h0, 32'h66, 2'd3, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0);
`ifdef DMEM_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      check("to stall", {31'b0, stall}, 32'h1);
      check("to mem_addr", {16'b0, mem_addr}, 32'h0AAA);
    end
    tick();
    check("to abort stall", {31'b0, stall}, 32'h0);
    check("to abort mem_req", {31'b0, mem_req}, 32'h0);
    check("to wb_valid", {31'b0, wb_valid}, 32'h1);
    check("to wb_dm_q", wb_dm_q, 32'h0);
    check("to err", {31'b0, err}, 32'h1);
    check("to stall_cnt", {16'b0, stall_cnt}, 32'd4);
    for (int k = 0; k < 5; k++) tick();
    check("to wb_valid pulse", {31'b0, wb_valid}, 32'h0);
    check("to err sticky", {31'b0, err}, 32'h1);
    drive(1, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0);
    tick();
    check("to err reset", {31'b0, err}, 32'h0);
`else
    for (int k = 0; k < 20; k++) tick();
    check("wait stall", {31'b0, stall}, 32'h1);
    check("wait err", {31'b0, err}, 32'h0);
    check("wait mem_addr", {16'b0, mem_addr}, 32'h0AAA);
    drive(0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 1, 32'h1357);
    tick();
    check("wait wb_valid", {31'b0, wb_valid}, 32'h1);
    check("wait wb_dm_q", wb_dm_q, 32'h1357);
    drive(0, 1, 1, 0, 16'h0BBB, 32'h1, 32'h0, 2'd0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0);
    for (int k = 0; k < 65540; k++) tick();
    check("sat stall_cnt", {16'b0, stall_cnt}, 32'h0000FFFF);
    check("sat model", {16'b0, stall_cnt}, m_scnt);
`endif

    // Random traffic against the model.
    drive(1, 0, 0, 0, 16'h0, 32'h0, 32'h0, 2'd0, 0, 32'h0);
    tick();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            16'($urandom), $urandom, $urandom, 2'($urandom),
            m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0), $urandom);
      tick();
      check_model(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
